// File: rtl/leading_zero_normaliser_pkg.sv
// Shared types and helpers for the iterative leading-zero normaliser.
package leading_zero_normaliser_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Ceiling log2 usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/leading_zero_shift_stage.sv
// One binary-search step: shift left by 2^stage when the top 2^stage bits are clear.
module leading_zero_shift_stage #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned K_WIDTH = 3
) (
   input  logic [WIDTH-1:0]   value,
   input  logic [K_WIDTH-1:0] stage,
   output logic [WIDTH-1:0]   shifted_c,
   output logic               take_c
);

   logic [31:0]      amount;
   logic [WIDTH-1:0] top_mask;

   always_comb begin
      amount    = 32'd1 << stage;
      top_mask  = ~({WIDTH{1'b1}} >> amount);
      take_c    = (value & top_mask) == '0;
      shifted_c = take_c ? (value << amount) : value;
   end

endmodule

// File: rtl/leading_zero_normaliser.sv
// Iterative normalising shifter: shifts an operand left until its MSB is set,
// one power-of-two stage per cycle, and reports the shift applied.
module leading_zero_normaliser
   import leading_zero_normaliser_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [WIDTH-1:0]              operand,
   input  logic                          operand_valid,
   output logic                          operand_ready,
   output logic [WIDTH-1:0]              normalised,
   output logic [clog2(WIDTH):0]         count,
   output logic                          zero,
   output logic                          result_valid,
   input  logic                          result_ready
);

   localparam int unsigned STAGES      = clog2(WIDTH);
   localparam int unsigned COUNT_WIDTH = STAGES + 1;
   localparam int unsigned K_WIDTH     = (clog2(STAGES) > 0) ? clog2(STAGES) : 1;

   state_t                  state;
   logic [K_WIDTH-1:0]      k;
   logic [WIDTH-1:0]        shifted_c;
   logic                    take_c;
   logic [COUNT_WIDTH-1:0]  step_c;

   // The shift register doubles as the normalised output.
   leading_zero_shift_stage #(
      .WIDTH   (WIDTH),
      .K_WIDTH (K_WIDTH)
   ) u_stage (
      .value     (normalised),
      .stage     (k),
      .shifted_c (shifted_c),
      .take_c    (take_c)
   );

   always_comb begin
      step_c = '0;
      if (take_c) step_c = COUNT_WIDTH'(1) << k;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         operand_ready <= 1'b1;
         result_valid  <= 1'b0;
         normalised    <= '0;
         count         <= '0;
         zero          <= 1'b0;
         k             <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (operand_valid) begin
                  normalised    <= operand;
                  count         <= '0;
                  k             <= K_WIDTH'(STAGES - 1);
                  zero          <= (operand == '0);
                  operand_ready <= 1'b0;
                  state         <= SHIFT;
               end
            end
            SHIFT: begin
               if (take_c) normalised <= shifted_c;
               if (k == '0) begin
                  // A zero operand would search to WIDTH-1; report WIDTH instead.
                  if (zero) begin
                     count      <= COUNT_WIDTH'(WIDTH);
                     normalised <= '0;
                  end else begin
                     count <= count + step_c;
                  end
                  result_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  count <= count + step_c;
                  k     <= k - K_WIDTH'(1);
               end
            end
            DONE: begin
               if (result_ready) begin
                  result_valid  <= 1'b0;
                  operand_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_leading_zero_normaliser.sv
// Self-checking bench for leading_zero_normaliser (WIDTH=32).
module tb_leading_zero_normaliser;

   logic        clock;
   logic        reset_n;
   logic [31:0] operand;
   logic        operand_valid;
   logic        operand_ready;
   logic [31:0] normalised;
   logic [5:0]  count;
   logic        zero;
   logic        result_valid;
   logic        result_ready;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] op;
      logic [31:0] norm;
      int          cnt;
      logic        z;
   } vec_t;

   vec_t tbl[6];

   leading_zero_normaliser #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .operand       (operand),
      .operand_valid (operand_valid),
      .operand_ready (operand_ready),
      .normalised    (normalised),
      .count         (count),
      .zero          (zero),
      .result_valid  (result_valid),
      .result_ready  (result_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Reference: count leading zeroes by scanning from the MSB.
   task automatic model(input logic [31:0] op, output logic [31:0] n, output int c,
                        output logic z);
      c = 0;
      while (c < 32 && op[31-c] == 1'b0) c++;
      z = (op == 32'd0);
      n = z ? 32'd0 : (op << c);
   endtask

   // Runs one transaction; stall = cycles result_ready stays low once result_valid is up.
   task automatic do_op(input logic [31:0] op, input int stall, input bit hold,
                        output logic [31:0] n, output logic [5:0] c, output logic z,
                        output int lat);
      int guard;
      guard = 0;
      while (!operand_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      check("ready_before_op", 64'(operand_ready), 64'd1);
      operand       = op;
      operand_valid = 1'b1;
      result_ready  = (stall == 0);
      @(negedge clock);
      if (hold) operand = ~op;
      else operand_valid = 1'b0;
      check("ready_low_in_shift", 64'(operand_ready), 64'd0);
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      n = normalised;
      c = count;
      z = zero;
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         check("stall_valid", 64'(result_valid), 64'd1);
         check("stall_ready", 64'(operand_ready), 64'd0);
         check("stall_norm", 64'(normalised), 64'(n));
         check("stall_count", 64'(count), 64'(c));
      end
      result_ready  = 1'b1;
      operand_valid = 1'b0;
      @(negedge clock);
      check("post_hs_valid", 64'(result_valid), 64'd0);
      check("post_hs_ready", 64'(operand_ready), 64'd1);
   endtask

   task automatic run_and_check(input string name, input logic [31:0] op, input int stall,
                                input bit hold);
      logic [31:0] n, en;
      logic [5:0]  c;
      logic        z, ez;
      int          lat, ec;
      model(op, en, ec, ez);
      do_op(op, stall, hold, n, c, z, lat);
      check({name, "_latency"}, 64'(lat), 64'd5);
      check({name, "_norm"}, 64'(n), 64'(en));
      check({name, "_count"}, 64'(c), 64'(ec));
      check({name, "_zero"}, 64'(z), 64'(ez));
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] tn;
      int          tc;
      logic        tz;
      int          acc_cyc[2];
      logic [5:0]  res_cnt[2];
      logic [31:0] res_norm[2];
      int          n_acc, n_res;

      tbl[0] = '{32'h0000_0001, 32'h8000_0000, 31, 1'b0};
      tbl[1] = '{32'h8000_0000, 32'h8000_0000, 0,  1'b0};
      tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32, 1'b1};
      tbl[3] = '{32'h1234_5678, 32'h91A2_B3C0, 3,  1'b0};
      tbl[4] = '{32'h0000_FFFF, 32'hFFFF_0000, 16, 1'b0};
      tbl[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 1,  1'b0};

      reset_n       = 1'b0;
      operand       = '0;
      operand_valid = 1'b0;
      result_ready  = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_ready", 64'(operand_ready), 64'd1);
      check("reset_valid", 64'(result_valid), 64'd0);
      check("reset_norm", 64'(normalised), 64'd0);
      check("reset_count", 64'(count), 64'd0);
      check("reset_zero", 64'(zero), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Fixed vectors with hand-derived expectations.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] n;
         logic [5:0]  c;
         logic        z;
         int          lat;
         do_op(tbl[i].op, i % 2, 1'b0, n, c, z, lat);
         check("tbl_latency", 64'(lat), 64'd5);
         check("tbl_norm", 64'(n), 64'(tbl[i].norm));
         check("tbl_count", 64'(c), 64'(tbl[i].cnt));
         check("tbl_zero", 64'(z), 64'(tbl[i].z));
      end

      // Back-pressure with a concurrently held operand_valid.
      run_and_check("backpressure", 32'h00F0_0000, 3, 1'b1);
      repeat (2) begin
         @(negedge clock);
         check("no_spurious_valid", 64'(result_valid), 64'd0);
      end

      // Reset in the middle of SHIFT.
      operand       = 32'h0001_0000;
      operand_valid = 1'b1;
      result_ready  = 1'b1;
      @(negedge clock);
      operand_valid = 1'b0;
      @(negedge clock);
      check("mid_reset_busy", 64'(operand_ready), 64'd0);
      #2 reset_n = 1'b0;
      #1;
      check("mid_reset_valid", 64'(result_valid), 64'd0);
      check("mid_reset_ready", 64'(operand_ready), 64'd1);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clock);
         check("mid_reset_no_result", 64'(result_valid), 64'd0);
      end
      run_and_check("after_reset", 32'h0001_0000, 0, 1'b0);

      // Back-to-back with both handshakes held high.
      n_acc = 0;
      n_res = 0;
      operand       = 32'h0000_0003;
      operand_valid = 1'b1;
      result_ready  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (operand_ready && operand_valid && n_acc < 2) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         if (result_valid && n_res < 2) begin
            res_cnt[n_res]  = count;
            res_norm[n_res] = normalised;
            n_res++;
         end
         if (n_res == 2) break;
         @(negedge clock);
         if (n_acc == 1) operand = 32'h4000_0000;
      end
      operand_valid = 1'b0;
      check("b2b_results", 64'(n_res), 64'd2);
      check("b2b_accepts", 64'(n_acc), 64'd2);
      if (n_acc == 2) check("b2b_interval", 64'(acc_cyc[1] - acc_cyc[0]), 64'd7);
      if (n_res == 2) begin
         check("b2b_count0", 64'(res_cnt[0]), 64'd30);
         check("b2b_norm0", 64'(res_norm[0]), 64'hC000_0000);
         check("b2b_count1", 64'(res_cnt[1]), 64'd1);
         check("b2b_norm1", 64'(res_norm[1]), 64'h8000_0000);
      end
      @(negedge clock);

      // Randomised operands against the scanning reference.
      for (int i = 0; i < 30; i++) begin
         r = $urandom;
         r = r >> $urandom_range(0, 32);
         model(r, tn, tc, tz);
         run_and_check("random", r, int'($urandom_range(0, 2)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
